// File: rtl/dct_quantization.sv
`default_nettype none
// ============================================================================
//  Module   : dct_quantization
//  Purpose  : Forward JPEG baseline transform for one 8x8 luminance block.
//             Level shift, separable fixed-point 2-D DCT-II (rows first,
//             then columns), and quantization with the Annex K luminance
//             table. One block in flight, fixed latency.
//  Ports    : clk       - rising-edge clock
//             rst_n     - synchronous active-low reset
//             in_valid  - mcu holds a block to transform
//             in_ready  - engine idle, a block can be accepted
//             mcu       - 64 unsigned 8-bit pixels, k=y*8+x at [8k+7:8k]
//             out_valid - one-cycle pulse, dct holds a new result
//             dct       - 64 signed 16-bit quantized coefficients,
//                         k=v*8+u at [16k+15:16k], row-major
//  Timing   : counting the accept edge as edge 1, out_valid is raised on
//             edge LATENCY (ROW 64 + COL 64 + DONE 1 cycles after accept).
//  Revision : 1.0 - initial release
// ============================================================================
module dct_quantization #(
    parameter int COEF_FRAC = 12,
    parameter int LATENCY   = 130
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [511:0]  mcu,
    output logic          out_valid,
    output logic [1023:0] dct
);

    // Each pass (ROW, COL) takes (LATENCY - 2) / 2 = 64 cycles.
    localparam int         PASS_LEN = (LATENCY - 2) / 2;
    localparam logic [5:0] LAST_IDX = 6'(PASS_LEN - 1);

    // Annex K luminance quantization table, row-major.
    localparam int QT_TAB [64] = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99
    };

    // Reciprocals round(65536 / QT) folded into a constant ROM at elaboration.
    function automatic logic [64*13-1:0] build_r_tab();
        logic [64*13-1:0] tab;
        tab = '0;
        for (int k = 0; k < 64; k++) begin
            tab[k*13 +: 13] = 13'((65536 + QT_TAB[k] / 2) / QT_TAB[k]);
        end
        return tab;
    endfunction

    localparam logic [64*13-1:0] R_TAB = build_r_tab();

    // Cosine ROM entry C[u][x] in Q12. The angle index m = (2x+1)u mod 32
    // is folded into the first quadrant so only cos(m*pi/16), m=0..8, is
    // stored.
    function automatic logic signed [13:0] cos_coef(input logic [2:0] u,
                                                    input logic [2:0] x);
        logic [6:0]         arg;
        logic [5:0]         m;
        logic               neg;
        logic signed [13:0] mag;
        arg = {3'b000, x, 1'b1} * {4'b0000, u};
        m   = {1'b0, arg[4:0]};
        neg = 1'b0;
        if (m > 6'd16) begin
            m = 6'd32 - m;
        end
        if (m > 6'd8) begin
            m   = 6'd16 - m;
            neg = 1'b1;
        end
        case (m)
            6'd0:    mag = 14'sd2048;
            6'd1:    mag = 14'sd2009;
            6'd2:    mag = 14'sd1892;
            6'd3:    mag = 14'sd1703;
            6'd4:    mag = 14'sd1448;
            6'd5:    mag = 14'sd1138;
            6'd6:    mag = 14'sd784;
            6'd7:    mag = 14'sd400;
            default: mag = 14'sd0;
        endcase
        if (u == 3'd0) begin
            return 14'sd1448;
        end
        return neg ? -mag : mag;
    endfunction

    // Round half away from zero, drop COEF_FRAC bits, saturate to 16 bits.
    function automatic logic signed [15:0] round_sat(input logic signed [39:0] acc);
        logic [39:0]        mag;
        logic [39:0]        rmag;
        logic signed [40:0] val;
        mag  = acc[39] ? 40'(-acc) : 40'(acc);
        rmag = (mag + (40'd1 << (COEF_FRAC - 1))) >> COEF_FRAC;
        val  = acc[39] ? -$signed({1'b0, rmag}) : $signed({1'b0, rmag});
        if (val > 41'sd32767) begin
            return 16'sh7fff;
        end
        if (val < -41'sd32768) begin
            return 16'sh8000;
        end
        return val[15:0];
    endfunction

    // Q = sign(F) * ((|F| * R + 2^15) >> 16). The magnitude tops out near
    // 3277, so the result always fits in 16 bits.
    function automatic logic [15:0] quantize(input logic signed [15:0] f,
                                             input logic [12:0]        r);
        logic signed [16:0] fx;
        logic [16:0]        mag;
        logic [29:0]        prod;
        logic [15:0]        q;
        fx   = {f[15], f};
        mag  = fx[16] ? 17'(-fx) : 17'(fx);
        prod = {13'b0, mag} * {17'b0, r};
        prod = prod + 30'd32768;
        q    = {2'b00, prod[29:16]};
        return f[15] ? 16'(-q) : q;
    endfunction

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_ROW  = 2'd1,
        S_COL  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_next;
    logic                w_ready;
    logic [5:0]          r_idx;
    logic [7:0]          r_pix  [64];
    logic signed [15:0]  r_tmat [64];
    logic [1023:0]       r_dct;
    logic                r_out_valid;

    logic signed [29:0]  w_prod [8];
    logic signed [39:0]  w_acc;
    logic signed [15:0]  w_round;
    logic [15:0]         w_quant;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next  = r_state;
        w_ready = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_ready = 1'b1;
                if (in_valid) begin
                    w_next = S_ROW;
                end
            end
            S_ROW: begin
                if (r_idx == LAST_IDX) begin
                    w_next = S_COL;
                end
            end
            S_COL: begin
                if (r_idx == LAST_IDX) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // 8 parallel multipliers. ROW: r_idx = y*8+u, lane x multiplies
    // C[u][x] by s[y][x]. COL: r_idx = v*8+u, lane y multiplies C[v][y]
    // by T[y][u].
    // ------------------------------------------------------------------
    generate
        for (genvar i = 0; i < 8; i++) begin : g_mac
            localparam logic [2:0] LANE = 3'(i);
            logic [7:0]         px;
            logic signed [8:0]  s9;
            logic signed [13:0] coef;
            logic signed [15:0] op;

            assign px   = r_pix[{r_idx[5:3], LANE}];
            assign s9   = $signed({1'b0, px}) - 9'sd128;
            assign coef = (r_state == S_COL) ? cos_coef(r_idx[5:3], LANE)
                                             : cos_coef(r_idx[2:0], LANE);
            assign op   = (r_state == S_COL) ? r_tmat[{LANE, r_idx[2:0]}]
                                             : {{7{s9[8]}}, s9};
            assign w_prod[i] = coef * op;
        end
    endgenerate

    always_comb begin
        w_acc = '0;
        for (int j = 0; j < 8; j++) begin
            w_acc = w_acc + 40'(w_prod[j]);
        end
    end

    assign w_round = round_sat(w_acc);
    assign w_quant = quantize(w_round, R_TAB[int'(r_idx) * 13 +: 13]);

    // ------------------------------------------------------------------
    // Datapath registers. The pixel and intermediate buffers need no
    // reset: they are always written before they are read.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx       <= '0;
            r_dct       <= '0;
            r_out_valid <= 1'b0;
        end else begin
            r_out_valid <= (r_state == S_DONE);
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 64; k++) begin
                            r_pix[k] <= mcu[8*k +: 8];
                        end
                        r_idx <= '0;
                    end
                end
                S_ROW: begin
                    r_tmat[r_idx] <= w_round;
                    r_idx         <= (r_idx == LAST_IDX) ? 6'd0 : r_idx + 6'd1;
                end
                S_COL: begin
                    r_dct[16*r_idx +: 16] <= w_quant;
                    r_idx                 <= (r_idx == LAST_IDX) ? 6'd0 : r_idx + 6'd1;
                end
                default: begin
                    r_idx <= '0;
                end
            endcase
        end
    end

    assign in_ready  = w_ready;
    assign out_valid = r_out_valid;
    assign dct       = r_dct;

endmodule
`default_nettype wire

// File: tb/tb_dct_quantization.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dct_quantization
//  Purpose  : Self-checking bench for dct_quantization: fixed pattern
//             table, random blocks against a floating-point-derived
//             reference model, and handshake / abort / back-to-back
//             sequences.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_dct_quantization;

    localparam int  LATENCY = 130;
    localparam real PI      = 3.14159265358979323846;

    localparam int QT [64] = '{
        16, 11, 10, 16,  24,  40,  51,  61,
        12, 12, 14, 19,  26,  58,  60,  55,
        14, 13, 16, 24,  40,  57,  69,  56,
        14, 17, 22, 29,  51,  87,  80,  62,
        18, 22, 37, 56,  68, 109, 103,  77,
        24, 35, 55, 64,  81, 104, 113,  92,
        49, 64, 78, 87, 103, 121, 120, 101,
        72, 92, 95, 98, 112, 100, 103,  99
    };

    logic          clk = 1'b0;
    logic          rst_n;
    logic          in_valid;
    logic          in_ready;
    logic [511:0]  mcu;
    logic          out_valid;
    logic [1023:0] dct;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    dct_quantization #(
        .COEF_FRAC (12),
        .LATENCY   (LATENCY)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .mcu       (mcu),
        .out_valid (out_valid),
        .dct       (dct)
    );

    // ---------------- reference model ----------------
    function automatic longint rnd12(input longint a);
        longint m;
        m = (a < 0) ? -a : a;
        m = (m + 2048) / 4096;
        m = (a < 0) ? -m : m;
        if (m > 32767)  m = 32767;
        if (m < -32768) m = -32768;
        return m;
    endfunction

    function automatic logic [1023:0] model(input logic [511:0] p);
        longint c [8][8];
        longint s [8][8];
        longint t [8][8];
        longint acc, f, r, q;
        real    cv;
        logic [1023:0] res;
        res = '0;
        for (int u = 0; u < 8; u++) begin
            for (int x = 0; x < 8; x++) begin
                cv = 4096.0 * ((u == 0) ? (1.0 / $sqrt(2.0)) : 1.0) / 2.0
                     * $cos(real'((2*x+1)*u) * PI / 16.0);
                c[u][x] = longint'((cv >= 0.0) ? $floor(cv + 0.5) : -$floor(-cv + 0.5));
            end
        end
        for (int y = 0; y < 8; y++)
            for (int x = 0; x < 8; x++)
                s[y][x] = longint'(p[8*(8*y+x) +: 8]) - 128;
        for (int y = 0; y < 8; y++) begin
            for (int u = 0; u < 8; u++) begin
                acc = 0;
                for (int x = 0; x < 8; x++) acc += c[u][x] * s[y][x];
                t[y][u] = rnd12(acc);
            end
        end
        for (int v = 0; v < 8; v++) begin
            for (int u = 0; u < 8; u++) begin
                acc = 0;
                for (int y = 0; y < 8; y++) acc += c[v][y] * t[y][u];
                f = rnd12(acc);
                r = longint'($floor(65536.0 / real'(QT[8*v+u]) + 0.5));
                q = (f >= 0) ? (f * r + 32768) / 65536 : -((-f * r + 32768) / 65536);
                res[16*(8*v+u) +: 16] = 16'(q);
            end
        end
        return res;
    endfunction

    // ---------------- comparison helpers ----------------
    task automatic check_val(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_blk(input string name, input logic [1023:0] act,
                             input logic [1023:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            for (int k = 0; k < 64; k++) begin
                if (act[16*k +: 16] !== exp[16*k +: 16]) begin
                    $display("FAIL %s: dct[%0d] got %0d expected %0d", name, k,
                             $signed(act[16*k +: 16]), $signed(exp[16*k +: 16]));
                    break;
                end
            end
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] p;
        for (int i = 0; i < 16; i++) p[32*i +: 32] = $urandom();
        return p;
    endfunction

    // Present a block for one edge (the accept edge), then scramble mcu.
    task automatic send(input logic [511:0] p);
        @(negedge clk);
        in_valid = 1'b1;
        mcu      = p;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        mcu      = rand_block();
    endtask

    // Waits for out_valid; 'start' is the number of edges already elapsed
    // since the accept edge. out_valid is expected LATENCY-1 edges after it.
    task automatic wait_result(input string name, input logic [1023:0] exp,
                               input int start);
        int cyc;
        int busy_ok;
        cyc     = start;
        busy_ok = 1;
        while (cyc < 400) begin
            @(posedge clk);
            #1;
            cyc++;
            if (out_valid) break;
            if (in_ready) busy_ok = 0;
        end
        check_val({name, " latency"}, cyc, LATENCY - 1);
        check_val({name, " in_ready low while busy"}, busy_ok, 1);
        check_val({name, " in_ready with out_valid"}, in_ready, 1);
        check_blk(name, dct, exp);
        @(posedge clk);
        #1;
        check_val({name, " out_valid pulse width"}, out_valid, 0);
    endtask

    typedef struct {
        string         name;
        logic [511:0]  pix;
        logic [1023:0] exp;
    } vec_t;

    vec_t vecs [3];

    initial begin
        logic [511:0] pa, pb;
        int seen;

        rst_n    = 1'b0;
        in_valid = 1'b0;
        mcu      = '0;

        // ---- reset ----
        repeat (3) @(posedge clk);
        #1;
        check_val("reset in_ready", in_ready, 1);
        check_val("reset out_valid", out_valid, 0);
        check_blk("reset dct", dct, '0);
        rst_n = 1'b1;

        // ---- fixed pattern table ----
        vecs[0].name = "flat grey";
        vecs[0].pix  = {64{8'h80}};
        vecs[0].exp  = '0;
        vecs[1].name = "all zero";
        vecs[1].pix  = '0;
        vecs[1].exp  = '0;
        vecs[1].exp[15:0] = 16'hFFC0;
        vecs[2].name = "column stripes";
        for (int k = 0; k < 64; k++)
            vecs[2].pix[8*k +: 8] = ((k % 2) == 0) ? 8'hFF : 8'h00;
        vecs[2].exp = '0;
        vecs[2].exp[16*1 +: 16] = 16'd17;
        vecs[2].exp[16*3 +: 16] = 16'd14;
        vecs[2].exp[16*5 +: 16] = 16'd8;
        vecs[2].exp[16*7 +: 16] = 16'd15;

        for (int i = 0; i < 3; i++) begin
            send(vecs[i].pix);
            wait_result(vecs[i].name, vecs[i].exp, 0);
        end

        // ---- random blocks against the model ----
        for (int i = 0; i < 5; i++) begin
            pa = rand_block();
            send(pa);
            wait_result($sformatf("random %0d", i), model(pa), 0);
        end
        // Extreme pixels only (0x00 / 0xFF mix).
        for (int k = 0; k < 64; k++) pa[8*k +: 8] = ($urandom() % 2 == 0) ? 8'h00 : 8'hFF;
        send(pa);
        wait_result("extreme mix", model(pa), 0);

        // ---- in_valid while busy is ignored ----
        pa = rand_block();
        pb = rand_block();
        send(pa);
        repeat (30) @(posedge clk);
        @(negedge clk);
        check_val("busy in_ready", in_ready, 0);
        in_valid = 1'b1;
        mcu      = pb;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        wait_result("busy pulse ignored", model(pa), 31);

        // ---- abort by reset mid-ROW ----
        send(rand_block());
        repeat (20) @(posedge clk);
        #1;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        check_val("abort in_ready", in_ready, 1);
        check_blk("abort dct cleared", dct, '0);
        seen = 0;
        repeat (200) begin
            @(posedge clk);
            #1;
            if (out_valid) seen = 1;
        end
        check_val("abort no out_valid", seen, 0);
        pa = rand_block();
        send(pa);
        wait_result("after abort", model(pa), 0);

        // ---- back-to-back with in_valid held high ----
        pa = rand_block();
        pb = rand_block();
        @(negedge clk);
        in_valid = 1'b1;
        mcu      = pa;
        @(posedge clk);
        #1;
        mcu = pb;
        // The pulse-width edge inside wait_result is the accept edge of pb.
        wait_result("b2b first", model(pa), 0);
        in_valid = 1'b0;
        mcu      = rand_block();
        wait_result("b2b second", model(pb), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
